// File: rtl/mips_pkg.sv
// Shared widths, constants and FSM state encoding for the register-file debug arbiter.
package mips_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic [2:0] {
    StRun,
    StDrain,
    StHalted,
    StDbgRead,
    StDbgWrite,
    StAck
  } arb_state_e;

endpackage

// File: rtl/regfile_debug_arbiter_if.sv
// Debug-master side of the arbiter: halt control plus four-phase req/ack register access.
interface regfile_debug_arbiter_if;
  import mips_pkg::*;

  logic                  dbg_halt;
  logic                  dbg_req;
  logic                  dbg_we;
  logic [REG_ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0]     dbg_wdata;
  logic                  dbg_ack;
  logic [DATA_W-1:0]     dbg_rdata;
  logic                  dbg_halted;
  logic                  halt_forced;

  modport master (
    output dbg_halt, dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_ack, dbg_rdata, dbg_halted, halt_forced
  );

  modport slave (
    input  dbg_halt, dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_ack, dbg_rdata, dbg_halted, halt_forced
  );

endinterface

// File: rtl/regfile_debug_arbiter_drain_timer.sv
// Drain counter: clears on request, counts while enabled, flags the last allowed drain cycle.
module regfile_debug_arbiter_drain_timer #(
  parameter int unsigned DRAIN_TIMEOUT = 16,
  parameter int unsigned CNT_W         = 5
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign tc_o = (cnt_q == CNT_W'(DRAIN_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/regfile_debug_arbiter.sv
// Owns the register file address/write-enable inputs; muxes between core pass-through and a
// halt-then-access debug master. Writes to register 0 are always suppressed.
module regfile_debug_arbiter
  import mips_pkg::*;
#(
  parameter int unsigned DRAIN_TIMEOUT = 16,
  parameter int unsigned CNT_W         = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [REG_ADDR_W-1:0] core_addr_src,
  input  logic [REG_ADDR_W-1:0] core_addr_tgt,
  input  logic [REG_ADDR_W-1:0] core_addr_write,
  input  logic [DATA_W-1:0]     core_data_write,
  input  logic                  core_FLAG_register,
  input  logic                  core_idle,
  output logic                  core_stall,
  regfile_debug_arbiter_if.slave dbg,
  output logic [REG_ADDR_W-1:0] rf_addr_src,
  output logic [REG_ADDR_W-1:0] rf_addr_tgt,
  output logic [REG_ADDR_W-1:0] rf_addr_write,
  output logic [DATA_W-1:0]     rf_data_write,
  output logic                  rf_FLAG_register,
  input  logic [DATA_W-1:0]     rf_data_src
);

  arb_state_e        state_q, state_d;
  logic              ack_q, ack_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              forced_q, forced_d;
  logic              drain_tc;

  regfile_debug_arbiter_drain_timer #(
    .DRAIN_TIMEOUT (DRAIN_TIMEOUT),
    .CNT_W         (CNT_W)
  ) u_drain_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (state_q != StDrain),
    .en_i    ((state_q == StDrain) && !core_idle),
    .tc_o    (drain_tc)
  );

  always_comb begin
    state_d  = state_q;
    ack_d    = ack_q;
    rdata_d  = rdata_q;
    forced_d = forced_q;
    case (state_q)
      StRun: begin
        if (dbg.dbg_halt) state_d = StDrain;
      end
      StDrain: begin
        if (!dbg.dbg_halt) begin
          state_d = StRun;
        end else if (core_idle) begin
          state_d = StHalted;
        end else if (drain_tc) begin
          state_d  = StHalted;
          forced_d = 1'b1;
        end
      end
      StHalted: begin
        // A pending access wins over release so the master never loses a request.
        if (dbg.dbg_req) begin
          state_d = dbg.dbg_we ? StDbgWrite : StDbgRead;
        end else if (!dbg.dbg_halt) begin
          state_d  = StRun;
          forced_d = 1'b0;
        end
      end
      StDbgRead: begin
        rdata_d = rf_data_src;
        ack_d   = 1'b1;
        state_d = StAck;
      end
      StDbgWrite: begin
        ack_d   = 1'b1;
        state_d = StAck;
      end
      StAck: begin
        if (!dbg.dbg_req) begin
          ack_d   = 1'b0;
          state_d = StHalted;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= StRun;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
      forced_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      forced_q <= forced_d;
    end
  end

  always_comb begin
    rf_addr_src      = core_addr_src;
    rf_addr_tgt      = core_addr_tgt;
    rf_addr_write    = core_addr_write;
    rf_data_write    = core_data_write;
    rf_FLAG_register = 1'b0;
    case (state_q)
      StRun, StDrain: begin
        rf_FLAG_register = core_FLAG_register && (core_addr_write != REG_ZERO);
      end
      StDbgRead: begin
        rf_addr_src = dbg.dbg_addr;
      end
      StDbgWrite: begin
        rf_addr_write = dbg.dbg_addr;
        rf_data_write = dbg.dbg_wdata;
        // Gating with reset_n keeps a reset landing on the commit edge from writing.
        rf_FLAG_register = (dbg.dbg_addr != REG_ZERO) && reset_n;
      end
      default: ;
    endcase
  end

  assign core_stall      = (state_q != StRun);
  assign dbg.dbg_halted  = (state_q == StHalted) || (state_q == StDbgRead) ||
                           (state_q == StDbgWrite) || (state_q == StAck);
  assign dbg.dbg_ack     = ack_q;
  assign dbg.dbg_rdata   = rdata_q;
  assign dbg.halt_forced = forced_q;

endmodule
